// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared floating-point types, flag indices and bias helper
// Contents:
//   fp_class_t : operand/result class {FP_ZERO, FP_NORM, FP_INF, FP_NAN}
//   FLAG_*     : bit positions inside the 4-bit {invalid, overflow, underflow, inexact} flag vector
//   fp_bias()  : exponent bias 2^(exp_w-1)-1 for a given exponent field width
package fp_pkg;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_t;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// rtl/fp_mul_pipe_if.sv - operand/result handshake bundle for fp_mul_pipe
// Signals (W = 1+EXP_W+MAN_W):
//   in_valid/in_ready         : operand pair handshake
//   in_a, in_b [W-1:0]        : operands {sign, exp, man}
//   in_tag [TAG_W-1:0]        : sideband tag
//   out_valid/out_ready       : result handshake
//   out_z [W-1:0]             : product
//   out_tag [TAG_W-1:0]       : tag of the result
//   out_flags [3:0]           : {invalid, overflow, underflow, inexact}
// Modports: master drives operands and out_ready; slave is the multiplier.
interface fp_mul_pipe_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int TAG_W = 4
);

  logic                   in_valid;
  logic                   in_ready;
  logic [EXP_W+MAN_W:0]   in_a;
  logic [EXP_W+MAN_W:0]   in_b;
  logic [TAG_W-1:0]       in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W:0]   out_z;
  logic [TAG_W-1:0]       out_tag;
  logic [3:0]             out_flags;

  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_z, out_tag, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_z, out_tag, out_flags
  );

endinterface

// File: rtl/fp_mul_round.sv
// rtl/fp_mul_round.sv - combinational normalise/round/range-check for the normal product path
// Optional feature macro: FP_MUL_RNE_EN (defined: round-to-nearest-even, undefined: truncate).
// Ports:
//   i_p     [2*MAN_W+1:0] : raw product {1,ma} x {1,mb}
//   i_e     [EXP_W+1:0]   : signed biased exponent ea+eb-BIAS
//   o_man   [MAN_W-1:0]   : stored mantissa of the result
//   o_exp   [EXP_W-1:0]   : biased exponent field of the result
//   o_flags [3:0]         : {invalid, overflow, underflow, inexact}
module fp_mul_round
  import fp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic [2*MAN_W+1:0]      i_p,
  input  logic signed [EXP_W+1:0] i_e,
  output logic [MAN_W-1:0]        o_man,
  output logic [EXP_W-1:0]        o_exp,
  output logic [3:0]              o_flags
);

  localparam int PW = 2 * MAN_W + 2;
  localparam logic signed [EXP_W+1:0] ONE_S  = (EXP_W+2)'(1);
  localparam logic signed [EXP_W+1:0] ZERO_S = (EXP_W+2)'(0);
  localparam logic signed [EXP_W+1:0] EMAX_S = (EXP_W+2)'((1 << EXP_W) - 1);

  logic [PW-1:0]            w_q;
  logic signed [EXP_W+1:0]  w_e_n;
  logic signed [EXP_W+1:0]  w_e_r;
  logic [MAN_W-1:0]         w_kept;
  logic                     w_guard;
  logic                     w_sticky;
  logic                     w_inc;
  logic [MAN_W:0]           w_sum;

  always_comb begin
    // The product of two [1,2) significands lies in [1,4): at most one
    // right shift is needed. Left-aligning the smaller case instead keeps a
    // single set of kept/guard/sticky bit positions for both cases.
    w_q      = i_p[PW-1] ? i_p : {i_p[PW-2:0], 1'b0};
    w_e_n    = i_p[PW-1] ? (i_e + ONE_S) : i_e;
    w_kept   = w_q[PW-2 -: MAN_W];
    w_guard  = w_q[MAN_W];
    w_sticky = |w_q[MAN_W-1:0];
`ifdef FP_MUL_RNE_EN
    w_inc    = w_guard & (w_sticky | w_kept[0]);
`else
    w_inc    = 1'b0;
`endif
    // A carry out of the stored mantissa leaves the low bits all zero,
    // which is exactly the renormalised 1.000... significand.
    w_sum    = {1'b0, w_kept} + {{MAN_W{1'b0}}, w_inc};
    w_e_r    = w_sum[MAN_W] ? (w_e_n + ONE_S) : w_e_n;

    o_flags = 4'b0000;
    o_flags[FLAG_INEXACT] = w_guard | w_sticky;
    o_man = w_sum[MAN_W-1:0];
    o_exp = w_e_r[EXP_W-1:0];
    if (w_e_r >= EMAX_S) begin
      o_man = '0;
      o_exp = '1;
      o_flags[FLAG_OVERFLOW] = 1'b1;
      o_flags[FLAG_INEXACT]  = 1'b1;
    end else if (w_e_r <= ZERO_S) begin
      o_man = '0;
      o_exp = '0;
      o_flags[FLAG_UNDERFLOW] = 1'b1;
      o_flags[FLAG_INEXACT]   = 1'b1;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - pipelined floating-point multiplier with valid/ready handshake and tag
// Optional feature macro: FP_MUL_RNE_EN (rounding mode, consumed in fp_mul_round).
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : fp_mul_pipe_if.slave (operands, tag, result, flags, both handshakes)
// Pipeline: capture -> S1 classify/exponent -> S2 multiply -> S3 round/pack (output regs).
// Result appears 3 cycles after the accept edge; one whole-pipe stall signal.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int TAG_W = 4
) (
  input logic          clk,
  input logic          rst_n,
  fp_mul_pipe_if.slave bus
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic [EXP_W+1:0] BIAS_V = (EXP_W+2)'(fp_bias(EXP_W));
  // Canonical quiet NaN: positive, all-ones exponent, mantissa MSB set.
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Capture stage
  logic                    r0_valid;
  logic [W-1:0]            r0_a;
  logic [W-1:0]            r0_b;
  logic [TAG_W-1:0]        r0_tag;
  // S1 results
  logic                    r1_valid;
  logic                    r1_sign;
  fp_class_t               r1_cls;
  logic signed [EXP_W+1:0] r1_e;
  logic [MAN_W:0]          r1_ma;
  logic [MAN_W:0]          r1_mb;
  logic [TAG_W-1:0]        r1_tag;
  // S2 results
  logic                    r2_valid;
  logic                    r2_sign;
  fp_class_t               r2_cls;
  logic signed [EXP_W+1:0] r2_e;
  logic [PW-1:0]           r2_p;
  logic [TAG_W-1:0]        r2_tag;
  // Output registers
  logic                    r_out_valid;
  logic [W-1:0]            r_out_z;
  logic [TAG_W-1:0]        r_out_tag;
  logic [3:0]              r_out_flags;

  logic                    w_adv;
  fp_class_t               w_ca;
  fp_class_t               w_cb;
  fp_class_t               w_cls;
  logic                    w_sign;
  logic signed [EXP_W+1:0] w_e;
  logic [MAN_W:0]          w_ma;
  logic [MAN_W:0]          w_mb;
  logic [MAN_W-1:0]        w_rnd_man;
  logic [EXP_W-1:0]        w_rnd_exp;
  logic [3:0]              w_rnd_flags;
  logic [W-1:0]            w_z;
  logic [3:0]              w_flags;

  function automatic fp_class_t classify(input logic [W-1:0] x);
    fp_class_t c;
    if (x[W-2 -: EXP_W] == '0) begin
      c = FP_ZERO;                          // subnormals are flushed here
    end else if (x[W-2 -: EXP_W] == '1) begin
      c = (x[MAN_W-1:0] == '0) ? FP_INF : FP_NAN;
    end else begin
      c = FP_NORM;
    end
    return c;
  endfunction

  // The whole pipe moves together; only a held result blocks it.
  assign w_adv         = !(r_out_valid && !bus.out_ready);
  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_out_valid;
  assign bus.out_z     = r_out_z;
  assign bus.out_tag   = r_out_tag;
  assign bus.out_flags = r_out_flags;

  // S1: classify operands and decide the result class up front, so that
  // the special cases never depend on the arithmetic path.
  always_comb begin
    w_ca   = classify(r0_a);
    w_cb   = classify(r0_b);
    w_sign = r0_a[W-1] ^ r0_b[W-1];
    if (w_ca == FP_NAN || w_cb == FP_NAN ||
        (w_ca == FP_INF && w_cb == FP_ZERO) ||
        (w_ca == FP_ZERO && w_cb == FP_INF)) begin
      w_cls = FP_NAN;
    end else if (w_ca == FP_INF || w_cb == FP_INF) begin
      w_cls = FP_INF;
    end else if (w_ca == FP_ZERO || w_cb == FP_ZERO) begin
      w_cls = FP_ZERO;
    end else begin
      w_cls = FP_NORM;
    end
    w_e  = {2'b00, r0_a[W-2 -: EXP_W]} + {2'b00, r0_b[W-2 -: EXP_W]} - BIAS_V;
    w_ma = {1'b1, r0_a[MAN_W-1:0]};
    w_mb = {1'b1, r0_b[MAN_W-1:0]};
  end

  // S3 arithmetic path
  fp_mul_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .i_p     (r2_p),
    .i_e     (r2_e),
    .o_man   (w_rnd_man),
    .o_exp   (w_rnd_exp),
    .o_flags (w_rnd_flags)
  );

  // S3 special-result override and packing
  always_comb begin
    w_z     = '0;
    w_flags = 4'b0000;
    case (r2_cls)
      FP_NAN: begin
        w_z = QNAN;
        w_flags[FLAG_INVALID] = 1'b1;
      end
      FP_INF:  w_z = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      FP_ZERO: w_z = {r2_sign, {(EXP_W+MAN_W){1'b0}}};
      default: begin
        w_z     = {r2_sign, w_rnd_exp, w_rnd_man};
        w_flags = w_rnd_flags;
      end
    endcase
  end

  // Valid chain and output registers (reset)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r0_valid    <= 1'b0;
      r1_valid    <= 1'b0;
      r2_valid    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_z     <= '0;
      r_out_tag   <= '0;
      r_out_flags <= 4'b0000;
    end else if (w_adv) begin
      r0_valid    <= bus.in_valid;
      r1_valid    <= r0_valid;
      r2_valid    <= r1_valid;
      r_out_valid <= r2_valid;
      // Only real results overwrite the output data, so bubbles never
      // expose unreset stage contents.
      if (r2_valid) begin
        r_out_z     <= w_z;
        r_out_tag   <= r2_tag;
        r_out_flags <= w_flags;
      end
    end
  end

  // Stage data registers (no reset needed, qualified by the valid chain)
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r0_a    <= bus.in_a;
      r0_b    <= bus.in_b;
      r0_tag  <= bus.in_tag;
      r1_sign <= w_sign;
      r1_cls  <= w_cls;
      r1_e    <= w_e;
      r1_ma   <= w_ma;
      r1_mb   <= w_mb;
      r1_tag  <= r0_tag;
      r2_sign <= r1_sign;
      r2_cls  <= r1_cls;
      r2_e    <= r1_e;
      r2_p    <= PW'(r1_ma) * PW'(r1_mb);
      r2_tag  <= r1_tag;
    end
  end

endmodule
